single_buffer: RTL and testbench
================================

# single_buffer

Single-frame JPEG capture buffer between a parallel-output camera, an external asynchronous 16-bit SRAM and a microcontroller SPI master. After reset it captures one compressed frame into SRAM (byte n at address n) until the FF D9 end-of-image marker, then raises `frame_ready`. The microcontroller reads the frame length and frame bytes over SPI; pulsing `reset` re-arms a new capture. All logic runs on `clk_in`; camera and SPI inputs are oversampled.

## Interface
- No parameters.
- clk_in  in  1  system clock; ≥4× pclk rate and ≥4× spi_clk rate
- reset  in  1  asynchronous, active-low; also re-arms capture
- camera_vsync  in  1  frame valid, high during frame
- camera_hsync  in  1  line valid, high during valid bytes
- camera_pclk  in  1  pixel clock; data sampled on its rising edge
- camera_data  in  8  JPEG byte stream
- camera_xclk  out  1  camera master clock, clk_in/2
- sram_addr  out  16  word address
- sram_we_n, sram_oe_n, sram_ce_a_n, sram_ub_a_n, sram_lb_a_n  out  1 each  active-low SRAM controls
- sram_data_io  inout  16  driven only during writes, else high-Z
- spi_clk  in  1  SPI clock, mode 0, MSB first
- spi_mosi  in  1  command data
- spi_miso  out  1  response data
- spi_select  in  1  active-low; high clears SPI bit counter and returns to command state
- frame_ready  out  1  frame stored, readable
- error  out  1  sticky capture error

## Operation
- Input sync: pclk, vsync, hsync, data, spi_clk, spi_mosi, spi_select through 2-flop synchronizers; edges detected on synchronized signals.
- Capture FSM: ARMED -> CAPTURE -> DONE | ERR.
  - ARMED/CAPTURE: each pclk rising edge with vsync=1 and hsync=1 stores one byte at address = byte count; count +1 (16-bit count, 17-bit length register).
  - Write cycle: addr and data_io = {8'h00, byte}; ce_n=0, lb_n=0, ub_n=1, oe_n=1; we_n low for 1 clk; data held 1 clk after we_n rises.
  - Byte D9 immediately following FF: stored, then DONE; frame_ready=1; length includes marker.
  - Error: vsync falls in CAPTURE before marker, or 65536 bytes stored without marker -> ERR, error=1, no further writes.
  - DONE/ERR: camera ignored until reset.
- SPI slave: 8-bit shift in on spi_clk rising; miso changes on spi_clk falling, MSB first; miso=0 during command bytes.
  - 0x7F: next 3 bytes return frame length, 24-bit big-endian (0 if not DONE), then back to command state.
  - 0xBF (DONE only): next `length` bytes return SRAM bytes 0..length-1 in order, then back to command state. Ignored if not DONE.
  - Any other command: ignored, no response.
  - Reads: oe_n=0, ce_n=0, lb_n=0, we_n=1, data_io high-Z; data[7:0] latched 2 clk after address. Next byte prefetched while current byte shifts.
- frame_ready stays 1 through readout until reset.

## Timing
- Reset values: sram_addr=0, we_n/oe_n/ce_a_n/ub_a_n/lb_a_n=1, data_io high-Z, miso=0, frame_ready=0, error=0, camera_xclk=0; FSMs ARMED/command; counters 0. SRAM contents untouched.
- Reset mid-capture or mid-readout: aborts immediately, frame discarded; capture restarts from address 0.
- Byte write completes ≤4 clk after synchronized pclk edge; frame_ready asserts ≤6 clk after the pclk edge carrying D9.
- First response bit on miso valid before the first spi_clk rising edge of the response byte.
- Only FF immediately followed by D9 ends the frame; lone FF is data.

## Test plan
- Reset low 20 clk, release -> all outputs at reset values, camera_xclk toggles every clk.
- Bytes 0x00..0x63 then FF D9 on pclk with vsync/hsync high -> SRAM addr n holds n for n<100, addr 100=0xFF, 101=0xD9; frame_ready=1, error=0.
- SPI 0x7F then 3 bytes -> 0x00, 0x00, 0x66.
- SPI 0xBF then 103 bytes -> 0x00..0x63, 0xFF, 0xD9, then 0x00 (103rd parsed as command 0x00).
- Reset, repeat capture and both reads -> identical results; frame_ready 0 until new FF D9.
- vsync falls after 10 bytes without marker -> error=1, frame_ready=0; 0x7F returns 0x000000.

Source files
------------

// File: rtl/single_buffer.sv
// rtl/single_buffer.sv - single JPEG frame capture into async SRAM with SPI readout
module single_buffer (
  input  logic        clk_in,
  input  logic        reset,
  input  logic        camera_vsync,
  input  logic        camera_hsync,
  input  logic        camera_pclk,
  input  logic [7:0]  camera_data,
  output logic        camera_xclk,
  output logic [15:0] sram_addr,
  output logic        sram_we_n,
  output logic        sram_oe_n,
  output logic        sram_ce_a_n,
  output logic        sram_ub_a_n,
  output logic        sram_lb_a_n,
  inout  wire  [15:0] sram_data_io,
  input  logic        spi_clk,
  input  logic        spi_mosi,
  output logic        spi_miso,
  input  logic        spi_select,
  output logic        frame_ready,
  output logic        error
);
  typedef enum logic [1:0] {ARMED, CAPTURE, DONE, ERR} cap_t;
  typedef enum logic [1:0] {S_CMD, S_LEN, S_DATA} spi_t;

  cap_t cap_state, cap_next;
  spi_t spi_state, spi_next;

  logic [2:0]  pclk_q, vs_q, sck_q;
  logic [1:0]  hs_q, mosi_q, sel_q;
  logic [7:0]  d_q1, d_q2;
  logic [16:0] len;
  logic        prev_ff, drive, rd_active;
  logic [1:0]  wphase, fcnt, resp_cnt;
  logic [7:0]  wbyte, pf;
  logic [2:0]  bitcnt;
  logic [6:0]  rx;
  logic [7:0]  sh, nb_r, nb;
  logic [15:0] len_lat;
  logic [16:0] sent;
  logic [23:0] len_val;
  logic [7:0]  rx_full;
  logic        sel_s, byte_ev, vs_fall, is_marker, sck_rise, sck_fall, byte_done;

  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      pclk_q <= '0; vs_q <= '0; sck_q <= '0;
      hs_q <= '0; mosi_q <= '0; sel_q <= 2'b11;
      d_q1 <= '0; d_q2 <= '0;
    end else begin
      pclk_q <= {pclk_q[1:0], camera_pclk};
      vs_q   <= {vs_q[1:0], camera_vsync};
      sck_q  <= {sck_q[1:0], spi_clk};
      hs_q   <= {hs_q[0], camera_hsync};
      mosi_q <= {mosi_q[0], spi_mosi};
      sel_q  <= {sel_q[0], spi_select};
      d_q1   <= camera_data;
      d_q2   <= d_q1;
    end
  end

  assign sel_s      = sel_q[1];
  assign byte_ev    = pclk_q[1] & ~pclk_q[2] & vs_q[1] & hs_q[1] &
                      ((cap_state == ARMED) || (cap_state == CAPTURE));
  assign vs_fall    = vs_q[2] & ~vs_q[1];
  assign is_marker  = prev_ff & (d_q2 == 8'hD9);
  assign sck_rise   = sck_q[1] & ~sck_q[2] & ~sel_s;
  assign sck_fall   = ~sck_q[1] & sck_q[2] & ~sel_s;
  assign rx_full    = {rx, mosi_q[1]};
  assign byte_done  = sck_rise & (bitcnt == 3'd7);
  assign frame_ready = (cap_state == DONE);
  assign error       = (cap_state == ERR);
  assign len_val     = frame_ready ? {7'd0, len} : 24'd0;
  assign sram_ub_a_n = 1'b1;
  assign sram_data_io = drive ? {8'h00, wbyte} : 16'hzzzz;

  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      cap_state <= ARMED;
      spi_state <= S_CMD;
    end else begin
      cap_state <= cap_next;
      spi_state <= spi_next;
    end
  end

  always_comb begin
    cap_next = cap_state;
    case (cap_state)
      ARMED, CAPTURE: begin
        if (byte_ev) begin
          if (is_marker)                 cap_next = DONE;
          else if (len[15:0] == 16'hFFFF) cap_next = ERR;
          else                           cap_next = CAPTURE;
        end else if ((cap_state == CAPTURE) && vs_fall) begin
          cap_next = ERR;
        end
      end
      default: cap_next = cap_state;
    endcase
  end

  // nb is the byte that will start shifting out on the next spi_clk fall
  always_comb begin
    spi_next = spi_state;
    nb       = 8'h00;
    if (sel_s) begin
      spi_next = S_CMD;
    end else if (byte_done) begin
      case (spi_state)
        S_CMD: begin
          if (rx_full == 8'h7F) begin
            spi_next = S_LEN;
            nb       = len_val[23:16];
          end else if ((rx_full == 8'hBF) && frame_ready) begin
            spi_next = S_DATA;
            nb       = pf;
          end
        end
        S_LEN: begin
          if (resp_cnt == 2'd0)      nb = len_lat[15:8];
          else if (resp_cnt == 2'd1) nb = len_lat[7:0];
          else                       spi_next = S_CMD;
        end
        S_DATA: begin
          if (sent + 17'd1 == len) spi_next = S_CMD;
          else                     nb = pf;
        end
        default: spi_next = S_CMD;
      endcase
    end
  end

  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      camera_xclk <= 1'b0;
      sram_addr   <= '0;
      sram_we_n   <= 1'b1;
      sram_oe_n   <= 1'b1;
      sram_ce_a_n <= 1'b1;
      sram_lb_a_n <= 1'b1;
      drive       <= 1'b0;
      wbyte       <= '0;
      wphase      <= '0;
      len         <= '0;
      prev_ff     <= 1'b0;
      rd_active   <= 1'b0;
      fcnt        <= '0;
      pf          <= '0;
      bitcnt      <= '0;
      rx          <= '0;
      sh          <= '0;
      nb_r        <= '0;
      resp_cnt    <= '0;
      len_lat     <= '0;
      sent        <= '0;
      spi_miso    <= 1'b0;
    end else begin
      camera_xclk <= ~camera_xclk;

      // write cycle: setup, we_n low, we_n high with data held, release
      case (wphase)
        2'd1: begin sram_we_n <= 1'b0; wphase <= 2'd2; end
        2'd2: begin sram_we_n <= 1'b1; wphase <= 2'd3; end
        2'd3: begin drive <= 1'b0; sram_ce_a_n <= 1'b1; sram_lb_a_n <= 1'b1; wphase <= 2'd0; end
        default: ;
      endcase
      if (byte_ev) begin
        sram_addr   <= len[15:0];
        wbyte       <= d_q2;
        drive       <= 1'b1;
        sram_ce_a_n <= 1'b0;
        sram_lb_a_n <= 1'b0;
        wphase      <= 2'd1;
        len         <= len + 17'd1;
        prev_ff     <= (d_q2 == 8'hFF);
      end

      if (fcnt == 2'd1) begin
        fcnt <= 2'd2;
      end else if (fcnt == 2'd2) begin
        pf   <= sram_data_io[7:0];
        fcnt <= 2'd0;
      end
      // once the final write has drained, park the SRAM in read mode with byte 0 prefetched
      if (frame_ready && (wphase == 2'd0) && !rd_active) begin
        rd_active   <= 1'b1;
        sram_addr   <= '0;
        sram_oe_n   <= 1'b0;
        sram_ce_a_n <= 1'b0;
        sram_lb_a_n <= 1'b0;
        fcnt        <= 2'd1;
      end

      if (sel_s) begin
        bitcnt   <= '0;
        spi_miso <= 1'b0;
        sh       <= '0;
        nb_r     <= '0;
        if (rd_active && (spi_state != S_CMD)) begin
          sram_addr <= '0;
          fcnt      <= 2'd1;
        end
      end else begin
        if (sck_rise) begin
          bitcnt <= bitcnt + 3'd1;
          rx     <= rx_full[6:0];
        end
        if (byte_done) begin
          nb_r <= nb;
          case (spi_state)
            S_CMD: begin
              if (spi_next == S_LEN) begin
                len_lat  <= len_val[15:0];
                resp_cnt <= 2'd0;
              end else if (spi_next == S_DATA) begin
                sent      <= '0;
                sram_addr <= 16'd1;
                fcnt      <= 2'd1;
              end
            end
            S_LEN: resp_cnt <= resp_cnt + 2'd1;
            S_DATA: begin
              sent <= sent + 17'd1;
              if (spi_next == S_CMD) sram_addr <= '0;
              else                   sram_addr <= sram_addr + 16'd1;
              fcnt <= 2'd1;
            end
            default: ;
          endcase
        end
        if (sck_fall) begin
          if (bitcnt == 3'd0) begin
            spi_miso <= nb_r[7];
            sh       <= {nb_r[6:0], 1'b0};
          end else begin
            spi_miso <= sh[7];
            sh       <= {sh[6:0], 1'b0};
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_single_buffer.sv
// tb/tb_single_buffer.sv - scoreboard bench for single_buffer: SRAM write monitor and SPI readout
module tb_single_buffer;
  logic        clk_in = 1'b0;
  logic        reset = 1'b0;
  logic        camera_vsync = 1'b0, camera_hsync = 1'b0, camera_pclk = 1'b0;
  logic [7:0]  camera_data = 8'h00;
  logic        camera_xclk;
  logic [15:0] sram_addr;
  logic        sram_we_n, sram_oe_n, sram_ce_a_n, sram_ub_a_n, sram_lb_a_n;
  wire  [15:0] sram_data_io;
  logic        spi_clk = 1'b0, spi_mosi = 1'b0, spi_select = 1'b1;
  logic        spi_miso, frame_ready, error;

  logic [7:0]  mem [0:65535];
  int          passed = 0, total = 0;
  logic [34:0] wr_q[$];
  logic [7:0]  rx_exp_q[$];
  logic [7:0]  rx_got_q[$];
  bit          mon_en = 1'b0;
  event        rx_ev;

  always #5 clk_in = ~clk_in;

  single_buffer dut (
    .clk_in(clk_in), .reset(reset),
    .camera_vsync(camera_vsync), .camera_hsync(camera_hsync),
    .camera_pclk(camera_pclk), .camera_data(camera_data), .camera_xclk(camera_xclk),
    .sram_addr(sram_addr), .sram_we_n(sram_we_n), .sram_oe_n(sram_oe_n),
    .sram_ce_a_n(sram_ce_a_n), .sram_ub_a_n(sram_ub_a_n), .sram_lb_a_n(sram_lb_a_n),
    .sram_data_io(sram_data_io),
    .spi_clk(spi_clk), .spi_mosi(spi_mosi), .spi_miso(spi_miso), .spi_select(spi_select),
    .frame_ready(frame_ready), .error(error)
  );

  // asynchronous SRAM model: low byte lane only
  assign sram_data_io = (!sram_oe_n && !sram_ce_a_n && sram_we_n) ? {8'h00, mem[sram_addr]} : 16'hzzzz;

  task automatic chk(input string name, input logic [39:0] act, input logic [39:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  always @(posedge sram_we_n) begin : wr_mon
    logic [34:0] e;
    if (mon_en && !sram_ce_a_n) begin
      mem[sram_addr] = sram_data_io[7:0];
      if (wr_q.size() == 0) begin
        total++;
        $display("FAIL sram_wr_unexpected: got addr %0h data %0h, required no write", sram_addr, sram_data_io);
      end else begin
        e = wr_q.pop_front();
        chk("sram_wr", {5'd0, sram_addr, sram_data_io, sram_lb_a_n, sram_oe_n, sram_ub_a_n}, {5'd0, e});
      end
    end
  end

  always @(rx_ev) begin : rx_mon
    logic [7:0] g, e;
    while (rx_got_q.size() > 0) begin
      g = rx_got_q.pop_front();
      if (rx_exp_q.size() == 0) begin
        total++;
        $display("FAIL spi_rx_unexpected: got %0h, required nothing", g);
      end else begin
        e = rx_exp_q.pop_front();
        chk("spi_rx", {32'd0, g}, {32'd0, e});
      end
    end
  end

  task automatic clks(input int n);
    repeat (n) @(negedge clk_in);
  endtask

  task automatic cam_byte(input logic [7:0] b, input logic [15:0] addr, input bit stored);
    camera_data = b;
    if (stored) wr_q.push_back({addr, 8'h00, b, 3'b011});
    clks(4);
    camera_pclk = 1'b1;
    clks(4);
    camera_pclk = 1'b0;
  endtask

  task automatic spi_byte(input logic [7:0] tx, input logic [7:0] exp);
    logic [7:0] r;
    rx_exp_q.push_back(exp);
    for (int i = 7; i >= 0; i--) begin
      spi_mosi = tx[i];
      clks(6);
      r[i] = spi_miso;
      spi_clk = 1'b1;
      clks(6);
      spi_clk = 1'b0;
    end
    rx_got_q.push_back(r);
    -> rx_ev;
  endtask

  task automatic spi_begin();
    spi_select = 1'b0;
    clks(6);
  endtask

  task automatic spi_end();
    clks(6);
    spi_select = 1'b1;
    clks(10);
  endtask

  task automatic rd_len(input logic [23:0] exp);
    spi_begin();
    spi_byte(8'h7F, 8'h00);
    spi_byte(8'h00, exp[23:16]);
    spi_byte(8'h00, exp[15:8]);
    spi_byte(8'h00, exp[7:0]);
    spi_end();
  endtask

  task automatic rd_frame();
    logic [7:0] e;
    spi_begin();
    spi_byte(8'hBF, 8'h00);
    for (int i = 0; i < 102; i++) begin
      e = (i < 100) ? 8'(i) : ((i == 100) ? 8'hFF : 8'hD9);
      spi_byte(8'h00, e);
    end
    spi_byte(8'h00, 8'h00);
    spi_end();
  endtask

  task automatic wait_ready();
    int k;
    k = 0;
    while (!frame_ready && k < 20) begin
      clks(1);
      k++;
    end
    chk("frame_ready", {39'd0, frame_ready}, 40'd1);
  endtask

  task automatic capture_frame();
    mon_en = 1'b1;
    camera_vsync = 1'b1;
    camera_hsync = 1'b1;
    clks(4);
    for (int n = 0; n < 100; n++) cam_byte(8'(n), 16'(n), 1'b1);
    cam_byte(8'hFF, 16'd100, 1'b1);
    clks(4);
    chk("ready_before_marker", {39'd0, frame_ready}, 40'd0);
    cam_byte(8'hD9, 16'd101, 1'b1);
    wait_ready();
    chk("error_clear", {39'd0, error}, 40'd0);
    camera_hsync = 1'b0;
    camera_vsync = 1'b0;
    clks(10);
    chk("ready_after_vsync", {39'd0, frame_ready}, 40'd1);
    chk("writes_drained", 40'(wr_q.size()), 40'd0);
    chk("mem0", {32'd0, mem[0]}, 40'h00);
    chk("mem99", {32'd0, mem[99]}, 40'h63);
    chk("mem100", {32'd0, mem[100]}, 40'hFF);
    chk("mem101", {32'd0, mem[101]}, 40'hD9);
  endtask

  task automatic pulse_reset();
    mon_en = 1'b0;
    reset = 1'b0;
    clks(3);
    chk("reset_ready", {38'd0, frame_ready, error}, 40'd0);
    reset = 1'b1;
    clks(4);
  endtask

  initial begin : watchdog
    #2ms;
    $display("FAIL timeout: simulation did not reach the end");
    $fatal(1);
  end

  initial begin
    reset = 1'b0;
    clks(20);
    chk("reset_outs",
        {24'd0, sram_addr[6:0], sram_we_n, sram_oe_n, sram_ce_a_n, sram_ub_a_n, sram_lb_a_n,
         spi_miso, frame_ready, error, camera_xclk},
        {24'd0, 7'd0, 5'b11111, 4'b0000});
    chk("reset_addr", {24'd0, sram_addr}, 40'd0);
    reset = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      clks(1);
      chk("xclk", {39'd0, camera_xclk}, {39'd0, k[0]});
    end
    chk("idle_outs", {32'd0, sram_we_n, sram_oe_n, sram_ce_a_n, sram_lb_a_n, spi_miso, frame_ready, error, 1'b0},
        {32'd0, 8'b11110000});

    capture_frame();
    rd_len(24'h000066);
    rd_frame();
    rd_len(24'h000066);

    pulse_reset();
    capture_frame();
    rd_len(24'h000066);
    rd_frame();

    pulse_reset();
    mon_en = 1'b1;
    camera_vsync = 1'b1;
    camera_hsync = 1'b1;
    clks(4);
    for (int n = 0; n < 10; n++) cam_byte((n == 3) ? 8'hFF : 8'(8'hA0 + n), 16'(n), 1'b1);
    camera_hsync = 1'b0;
    camera_vsync = 1'b0;
    clks(10);
    chk("error_set", {38'd0, error, frame_ready}, 40'b10);
    camera_vsync = 1'b1;
    camera_hsync = 1'b1;
    clks(4);
    cam_byte(8'hFF, 16'd10, 1'b0);
    cam_byte(8'hD9, 16'd11, 1'b0);
    clks(10);
    chk("error_sticky", {38'd0, error, frame_ready}, 40'b10);
    chk("no_writes_after_err", 40'(wr_q.size()), 40'd0);
    camera_hsync = 1'b0;
    camera_vsync = 1'b0;
    rd_len(24'h000000);
    spi_begin();
    spi_byte(8'hBF, 8'h00);
    spi_byte(8'h00, 8'h00);
    spi_end();

    clks(10);
    chk("rx_drained", 40'(rx_exp_q.size()), 40'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
